chacha_stream: RTL

CHACHA_STREAM -- requirements
Module: chacha_stream

---
 rtl/chacha_pkg.sv | 33 +++
 rtl/chacha_stream_cfg.sv | 52 +++++
 rtl/chacha_stream.sv | 127 ++++++++++++
 3 files changed

// File: rtl/chacha_pkg.sv
// Shared constants and types for the ChaCha keystream streamer.
// Holds the ChaCha block constants, config sizes and the control FSM state type.
package chacha_pkg;

   localparam int unsigned BLOCK_BYTES = 64;
   localparam int unsigned CFG_BYTES   = 48;

   localparam logic [31:0] SIGMA0 = 32'h61707865;
   localparam logic [31:0] SIGMA1 = 32'h3320646e;
   localparam logic [31:0] SIGMA2 = 32'h79622d32;
   localparam logic [31:0] SIGMA3 = 32'h6b206574;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StWait,
      StStream,
      StInc
   } state_e;

   // Byte idx (0..15) of the constant words, least-significant byte first.
   function automatic logic [7:0] sigma_byte(input logic [3:0] idx);
      logic [31:0] w;
      case (idx[3:2])
         2'd0:    w = SIGMA0;
         2'd1:    w = SIGMA1;
         2'd2:    w = SIGMA2;
         default: w = SIGMA3;
      endcase
      return w[{idx[1:0], 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/chacha_stream_cfg.sv
// 48-byte key/counter/nonce register file, block-input serializer and
// block-counter increment with sticky wrap flag.
module chacha_stream_cfg
   import chacha_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [5:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [5:0] rd_idx,
   output logic [7:0] rd_byte,
   input  logic       ctr_inc,
   output logic       ctr_wrap
);

   logic [7:0]  cfg_q [CFG_BYTES];
   logic [31:0] ctr;
   logic [32:0] ctr_sum;
   logic [5:0]  cfg_idx;

   assign ctr     = {cfg_q[35], cfg_q[34], cfg_q[33], cfg_q[32]};
   assign ctr_sum = {1'b0, ctr} + 33'd1;
   // Block bytes 16..63 map one-to-one onto config bytes 0..47.
   assign cfg_idx = rd_idx - 6'd16;

   always_comb begin
      rd_byte = 8'h00;
      if (rd_idx < 6'd16) begin
         rd_byte = sigma_byte(rd_idx[3:0]);
      end else begin
         rd_byte = cfg_q[cfg_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < CFG_BYTES; i++) begin
            cfg_q[i] <= 8'h00;
         end
         ctr_wrap <= 1'b0;
      end else if (ctr_inc) begin
         {cfg_q[35], cfg_q[34], cfg_q[33], cfg_q[32]} <= ctr_sum[31:0];
         if (ctr_sum[32]) begin
            ctr_wrap <= 1'b1;
         end
      end else if (wr_en && (wr_addr < 6'(CFG_BYTES))) begin
         cfg_q[wr_addr] <= wr_data;
      end
   end

endmodule

// File: rtl/chacha_stream.sv
// ChaCha stream cipher front end: loads the block core, then XORs the plaintext
// byte stream with keystream bytes, advancing the block counter every 64 bytes.
module chacha_stream
   import chacha_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cfg_we,
   input  logic [5:0] cfg_addr,
   input  logic [7:0] cfg_data,
   input  logic       start,
   output logic       busy,
   output logic       ctr_wrap,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic [7:0] blk_data_out,
   output logic       blk_write,
   input  logic [7:0] blk_data_in,
   output logic       blk_read,
   input  logic       blk_ready
);

   state_e     state_q, state_d;
   logic [5:0] idx_q, idx_d;
   logic       last_idx;
   logic       xfer;
   logic       cfg_inc;
   logic [7:0] ser_byte;
   logic       out_valid_q;
   logic [7:0] out_data_q;

   assign last_idx = (idx_q == 6'(BLOCK_BYTES - 1));
   assign xfer     = in_valid && in_ready;

   chacha_stream_cfg u_cfg (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (cfg_we && (state_q == StIdle)),
      .wr_addr  (cfg_addr),
      .wr_data  (cfg_data),
      .rd_idx   (idx_q),
      .rd_byte  (ser_byte),
      .ctr_inc  (cfg_inc),
      .ctr_wrap (ctr_wrap)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= 6'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StLoad;
               idx_d   = 6'd0;
            end
         end
         StLoad: begin
            idx_d = idx_q + 6'd1;
            if (last_idx) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (blk_ready) begin
               state_d = StStream;
               idx_d   = 6'd0;
            end
         end
         StStream: begin
            if (xfer) begin
               idx_d = idx_q + 6'd1;
               if (last_idx) begin
                  state_d = StInc;
               end
            end
         end
         StInc: begin
            state_d = StLoad;
            idx_d   = 6'd0;
         end
         default: begin
            state_d = StIdle;
            idx_d   = 6'd0;
         end
      endcase
   end

   always_comb begin
      busy         = (state_q != StIdle);
      blk_write    = (state_q == StLoad);
      blk_data_out = (state_q == StLoad) ? ser_byte : 8'h00;
      // A held output byte only blocks intake while the sink stalls it.
      in_ready     = (state_q == StStream) && (!out_valid_q || out_ready);
      blk_read     = in_valid && in_ready;
      cfg_inc      = (state_q == StInc);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
      end else if (xfer) begin
         out_valid_q <= 1'b1;
         out_data_q  <= in_data ^ blk_data_in;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule
